// File: rtl/pipeline_hazard_controller.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_hazard_controller
// Purpose  : Front-end sequencing for a five-stage MIPS pipeline. Each cycle
//            it decides whether PC and IF/ID advance, hold or take a bubble,
//            and whether ID/EX takes a bubble. It reacts to load-use hazards,
//            taken branches resolved in EX and data-memory wait states. It
//            also keeps saturating counters of stall cycles and redirects.
// Revision : 1.0 - initial release
// ============================================================================
module pipeline_hazard_controller #(
    parameter int FLUSH_CYCLES = 1,   // IF/ID bubbles per redirect, 1..15
    parameter int COUNT_WIDTH  = 16   // performance counter width
) (
    input  logic                   clock,
    input  logic                   reset,              // async, active-low
    input  logic [31:0]            decode_instruction,
    input  logic                   execute_mem_read,
    input  logic [4:0]             execute_rt,
    input  logic                   branch_taken,
    input  logic                   mem_busy,
    output logic                   pc_enable,
    output logic                   fetch_decode_enable,
    output logic                   fetch_decode_flush,
    output logic                   decode_execute_flush,
    output logic [COUNT_WIDTH-1:0] stall_cycles,
    output logic [COUNT_WIDTH-1:0] flush_events
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        FLUSH    = 2'd1,
        MEM_WAIT = 2'd2
    } state_t;

    // Value loaded into flush_left on a redirect: the redirect cycle itself is
    // the first bubble, so only FLUSH_CYCLES-1 remain afterwards.
    localparam logic [3:0]             FLUSH_RELOAD = 4'(FLUSH_CYCLES - 1);
    localparam bit                     HAS_FLUSH    = (FLUSH_CYCLES > 1);
    localparam logic [COUNT_WIDTH-1:0] COUNT_MAX    = '1;
    localparam logic [COUNT_WIDTH-1:0] COUNT_ONE    = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

    state_t     state;
    state_t     next_state;
    state_t     effective_state;
    logic [3:0] flush_left;
    logic [3:0] next_flush_left;
    logic       ret_is_flush;        // state to resume after a memory freeze
    logic       next_ret_is_flush;

    logic       pc_en_raw;
    logic       fd_en_raw;
    logic       fd_flush_raw;
    logic       de_flush_raw;
    logic       branch_accept;

    logic [COUNT_WIDTH-1:0] stall_count;
    logic [COUNT_WIDTH-1:0] flush_count;

    // ------------------------------------------------------------------
    // Decode-stage source fields
    // ------------------------------------------------------------------
    logic [5:0] dec_op;
    logic [4:0] dec_rs;
    logic [4:0] dec_rt;
    logic       rt_is_source;
    logic       load_use;
    logic       unused_dec_low;

    assign dec_op = decode_instruction[31:26];
    assign dec_rs = decode_instruction[25:21];
    assign dec_rt = decode_instruction[20:16];
    // Immediate/funct bits play no part in hazard detection.
    assign unused_dec_low = ^decode_instruction[15:0];

    // R-type, beq, bne and sw read rt; every other opcode only writes it.
    assign rt_is_source = (dec_op == 6'h00) || (dec_op == 6'h04) ||
                          (dec_op == 6'h05) || (dec_op == 6'h2B);

    // $zero never creates a dependency.
    assign load_use = execute_mem_read && (execute_rt != 5'd0) &&
                      ((execute_rt == dec_rs) ||
                       (rt_is_source && (execute_rt == dec_rt)));

    // Next-state and raw control decode; MEM_WAIT without mem_busy replays the saved state
    always_comb begin
        pc_en_raw         = 1'b0;
        fd_en_raw         = 1'b0;
        fd_flush_raw      = 1'b0;
        de_flush_raw      = 1'b0;
        branch_accept     = 1'b0;
        next_state        = state;
        next_flush_left   = flush_left;
        next_ret_is_flush = ret_is_flush;
        effective_state   = state;

        if (state == MEM_WAIT) begin
            effective_state = ret_is_flush ? FLUSH : RUN;
        end

        if (mem_busy) begin
            // Total freeze: every enable low, flush_left and branch untouched.
            next_state = MEM_WAIT;
            if (state != MEM_WAIT) begin
                next_ret_is_flush = (state == FLUSH);
            end
        end else begin
            case (effective_state)
                FLUSH: begin
                    pc_en_raw    = 1'b1;
                    fd_en_raw    = 1'b1;
                    fd_flush_raw = 1'b1;
                    de_flush_raw = 1'b1;
                    if (branch_taken) begin
                        // A fresh redirect restarts the bubble train.
                        branch_accept   = 1'b1;
                        next_flush_left = FLUSH_RELOAD;
                        next_state      = HAS_FLUSH ? FLUSH : RUN;
                    end else begin
                        if (flush_left != 4'd0) begin
                            next_flush_left = flush_left - 4'd1;
                        end
                        next_state = (flush_left <= 4'd1) ? RUN : FLUSH;
                    end
                end
                default: begin
                    if (branch_taken) begin
                        pc_en_raw     = 1'b1;
                        fd_en_raw     = 1'b1;
                        fd_flush_raw  = 1'b1;
                        de_flush_raw  = 1'b1;
                        branch_accept = 1'b1;
                        if (HAS_FLUSH) begin
                            next_flush_left = FLUSH_RELOAD;
                            next_state      = FLUSH;
                        end else begin
                            next_state = RUN;
                        end
                    end else if (load_use) begin
                        // Hold PC and IF/ID, bubble into EX for one cycle.
                        de_flush_raw = 1'b1;
                        next_state   = RUN;
                    end else begin
                        pc_en_raw  = 1'b1;
                        fd_en_raw  = 1'b1;
                        next_state = RUN;
                    end
                end
            endcase
        end
    end

    // Control state register with asynchronous return to RUN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= RUN;
            flush_left   <= 4'd0;
            ret_is_flush <= 1'b0;
        end else begin
            state        <= next_state;
            flush_left   <= next_flush_left;
            ret_is_flush <= next_ret_is_flush;
        end
    end

    // Saturating stall-cycle and redirect counters
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            if (!pc_en_raw && (stall_count != COUNT_MAX)) begin
                stall_count <= stall_count + COUNT_ONE;
            end
            if (branch_accept && (flush_count != COUNT_MAX)) begin
                flush_count <= flush_count + COUNT_ONE;
            end
        end
    end

    // While reset is low the whole pipeline is frozen.
    assign pc_enable            = reset & pc_en_raw;
    assign fetch_decode_enable  = reset & fd_en_raw;
    assign fetch_decode_flush   = reset & fd_flush_raw;
    assign decode_execute_flush = reset & de_flush_raw;
    assign stall_cycles         = stall_count;
    assign flush_events         = flush_count;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipeline_hazard_controller
// Purpose  : Self-checking bench. Two instances (FLUSH_CYCLES=3/COUNT_WIDTH=16
//            and FLUSH_CYCLES=1/COUNT_WIDTH=4) share one stimulus stream and
//            are compared every cycle against a bubble-count model, with
//            directed literal checks at the start.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipeline_hazard_controller;

    logic        clock;
    logic        reset;
    logic [31:0] decode_instruction;
    logic        execute_mem_read;
    logic [4:0]  execute_rt;
    logic        branch_taken;
    logic        mem_busy;

    logic        a_pc, a_fde, a_fdf, a_def;
    logic [15:0] a_stall, a_flush;
    logic        b_pc, b_fde, b_fdf, b_def;
    logic [3:0]  b_stall, b_flush;

    int tests_run = 0;
    int failures  = 0;

    pipeline_hazard_controller #(.FLUSH_CYCLES(3), .COUNT_WIDTH(16)) dut_a (
        .clock(clock), .reset(reset),
        .decode_instruction(decode_instruction),
        .execute_mem_read(execute_mem_read), .execute_rt(execute_rt),
        .branch_taken(branch_taken), .mem_busy(mem_busy),
        .pc_enable(a_pc), .fetch_decode_enable(a_fde),
        .fetch_decode_flush(a_fdf), .decode_execute_flush(a_def),
        .stall_cycles(a_stall), .flush_events(a_flush)
    );

    pipeline_hazard_controller #(.FLUSH_CYCLES(1), .COUNT_WIDTH(4)) dut_b (
        .clock(clock), .reset(reset),
        .decode_instruction(decode_instruction),
        .execute_mem_read(execute_mem_read), .execute_rt(execute_rt),
        .branch_taken(branch_taken), .mem_busy(mem_busy),
        .pc_enable(b_pc), .fetch_decode_enable(b_fde),
        .fetch_decode_flush(b_fdf), .decode_execute_flush(b_def),
        .stall_cycles(b_stall), .flush_events(b_flush)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: the controller is just "how many forced IF/ID bubbles
    // are still owed". A freeze leaves that number untouched.
    // ------------------------------------------------------------------
    int fcs[2]  = '{3, 1};
    int maxc[2] = '{65535, 15};
    int pending[2], stalls[2], flushes[2];
    int nxt_pending[2], nxt_stalls[2], nxt_flushes[2];

    function automatic bit model_load_use(input logic [31:0] ins, input logic rd, input logic [4:0] ert);
        logic [5:0] op;
        logic [4:0] rs, rt;
        bit reads_rt;
        op = ins[31:26];
        rs = ins[25:21];
        rt = ins[20:16];
        reads_rt = (op inside {6'h00, 6'h04, 6'h05, 6'h2B});
        return rd && (ert != 0) && ((ert == rs) || (reads_rt && ert == rt));
    endfunction

    always @(negedge clock) begin
        for (int k = 0; k < 2; k++) begin
            bit e_pc, e_fde, e_fdf, e_def;
            logic [3:0] got;
            int got_stall, got_flush;
            e_pc = 0; e_fde = 0; e_fdf = 0; e_def = 0;
            if (!reset) begin
                pending[k] = 0; stalls[k] = 0; flushes[k] = 0;
                nxt_pending[k] = 0; nxt_stalls[k] = 0; nxt_flushes[k] = 0;
            end else begin
                nxt_pending[k] = pending[k];
                nxt_stalls[k]  = stalls[k];
                nxt_flushes[k] = flushes[k];
                if (mem_busy) begin
                    nxt_stalls[k] = (stalls[k] < maxc[k]) ? stalls[k] + 1 : stalls[k];
                end else if (branch_taken) begin
                    {e_pc, e_fde, e_fdf, e_def} = 4'b1111;
                    nxt_pending[k] = fcs[k] - 1;
                    nxt_flushes[k] = (flushes[k] < maxc[k]) ? flushes[k] + 1 : flushes[k];
                end else if (pending[k] > 0) begin
                    {e_pc, e_fde, e_fdf, e_def} = 4'b1111;
                    nxt_pending[k] = pending[k] - 1;
                end else if (model_load_use(decode_instruction, execute_mem_read, execute_rt)) begin
                    e_def = 1;
                    nxt_stalls[k] = (stalls[k] < maxc[k]) ? stalls[k] + 1 : stalls[k];
                end else begin
                    e_pc = 1; e_fde = 1;
                end
            end
            got       = (k == 0) ? {a_pc, a_fde, a_fdf, a_def} : {b_pc, b_fde, b_fdf, b_def};
            got_stall = (k == 0) ? int'(a_stall) : int'(b_stall);
            got_flush = (k == 0) ? int'(a_flush) : int'(b_flush);
            check($sformatf("model%0d pc_enable", k),            32'(got[3]), 32'(e_pc));
            check($sformatf("model%0d fetch_decode_enable", k),  32'(got[2]), 32'(e_fde));
            check($sformatf("model%0d fetch_decode_flush", k),   32'(got[1]), 32'(e_fdf));
            check($sformatf("model%0d decode_execute_flush", k), 32'(got[0]), 32'(e_def));
            check($sformatf("model%0d stall_cycles", k),  32'(got_stall), 32'(stalls[k]));
            check($sformatf("model%0d flush_events", k),  32'(got_flush), 32'(flushes[k]));
        end
    end

    always @(posedge clock) begin
        if (reset) begin
            for (int k = 0; k < 2; k++) begin
                pending[k] = nxt_pending[k];
                stalls[k]  = nxt_stalls[k];
                flushes[k] = nxt_flushes[k];
            end
        end
    end

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic observe();
        @(negedge clock);
    endtask

    initial begin
        reset = 1'b0; branch_taken = 1'b1; mem_busy = 1'b0;
        execute_mem_read = 1'b0; execute_rt = 5'd0; decode_instruction = 32'h0;

        // Reset held with a branch pending: everything frozen.
        observe(); observe();
        check("reset pc_enable", 32'(a_pc), 0);
        check("reset fd_flush", 32'(a_fdf), 0);
        check("reset de_flush", 32'(a_def), 0);
        check("reset stall_cycles", 32'(a_stall), 0);
        check("reset flush_events", 32'(a_flush), 0);
        next_cycle();

        // Release with idle inputs.
        reset = 1'b1; branch_taken = 1'b0;
        observe();
        check("release pc_enable", 32'(a_pc), 1);
        check("release fd_enable", 32'(a_fde), 1);
        check("release fd_flush", 32'(a_fdf), 0);
        next_cycle();

        // Load-use: lw $8 in EX, add $10,$8,$9 in ID.
        execute_mem_read = 1'b1; execute_rt = 5'd8; decode_instruction = 32'h01095020;
        observe();
        check("loaduse pc_enable", 32'(a_pc), 0);
        check("loaduse fd_enable", 32'(a_fde), 0);
        check("loaduse de_flush", 32'(a_def), 1);
        next_cycle();
        execute_mem_read = 1'b0;
        observe();
        check("loaduse stall_cycles", 32'(a_stall), 1);
        check("loaduse resumes pc_enable", 32'(a_pc), 1);
        next_cycle();
        execute_mem_read = 1'b1; execute_rt = 5'd0;
        observe();
        check("zero rt no stall", 32'(a_pc), 1);
        next_cycle();
        execute_mem_read = 1'b0;

        // One-cycle branch pulse: 3 bubbles in A, 1 in B.
        branch_taken = 1'b1;
        observe();
        check("redirect A flush1", 32'(a_fdf), 1);
        check("redirect B flush1", 32'(b_fdf), 1);
        next_cycle();
        branch_taken = 1'b0;
        observe();
        check("redirect A flush2", 32'(a_fdf), 1);
        check("redirect A pc2", 32'(a_pc), 1);
        check("redirect B done", 32'(b_fdf), 0);
        next_cycle();
        observe();
        check("redirect A flush3", 32'(a_fdf), 1);
        next_cycle();
        observe();
        check("redirect A done", 32'(a_fdf), 0);
        check("redirect flush_events", 32'(a_flush), 1);
        next_cycle();

        // Freeze inside FLUSH.
        branch_taken = 1'b1;
        next_cycle();
        branch_taken = 1'b0; mem_busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            observe();
            check("freeze outputs", 32'({a_pc, a_fde, a_fdf, a_def}), 0);
            next_cycle();
        end
        mem_busy = 1'b0;
        observe();
        check("post-freeze flush a", 32'(a_fdf), 1);
        next_cycle();
        observe();
        check("post-freeze flush b", 32'(a_fdf), 1);
        next_cycle();
        observe();
        check("post-freeze run", 32'({a_pc, a_fdf}), 32'b10);
        check("post-freeze stall_cycles", 32'(a_stall), 4);
        check("post-freeze flush_events", 32'(a_flush), 2);
        next_cycle();

        // Simultaneous freeze, load-use and branch.
        mem_busy = 1'b1; branch_taken = 1'b1;
        execute_mem_read = 1'b1; execute_rt = 5'd8; decode_instruction = 32'h01095020;
        observe();
        check("simul freeze outputs", 32'({a_pc, a_fde, a_fdf, a_def}), 0);
        next_cycle();
        mem_busy = 1'b0;
        observe();
        check("simul flush_events held", 32'(a_flush), 2);
        check("simul redirect taken", 32'({a_pc, a_fde, a_fdf, a_def}), 32'b1111);
        next_cycle();
        branch_taken = 1'b0; execute_mem_read = 1'b0;
        observe();
        check("simul flush_events", 32'(a_flush), 3);
        next_cycle();
        next_cycle();

        // Saturation, then reset in the middle of a freeze entered from FLUSH.
        branch_taken = 1'b1;
        next_cycle();
        branch_taken = 1'b0; mem_busy = 1'b1;
        repeat (20) next_cycle();
        observe();
        check("B stall saturated", 32'(b_stall), 15);
        next_cycle();
        reset = 1'b0;
        observe();
        check("midfreeze reset stall A", 32'(a_stall), 0);
        check("midfreeze reset stall B", 32'(b_stall), 0);
        check("midfreeze reset flush A", 32'(a_flush), 0);
        check("midfreeze reset outputs", 32'({a_pc, a_fde, a_fdf, a_def}), 0);
        next_cycle();
        reset = 1'b1; mem_busy = 1'b0;
        observe();
        check("after reset RUN A", 32'({a_pc, a_fde, a_fdf, a_def}), 32'b1100);
        check("after reset RUN B", 32'({b_pc, b_fde, b_fdf, b_def}), 32'b1100);
        next_cycle();

        // Randomized traffic checked by the model every cycle.
        for (int n = 0; n < 3000; n++) begin
            logic [5:0] ops [6];
            ops = '{6'h00, 6'h04, 6'h05, 6'h2B, 6'h23, 6'h08};
            reset              = ($urandom_range(0, 199) != 0);
            mem_busy           = ($urandom_range(0, 9) < 2);
            branch_taken       = ($urandom_range(0, 9) == 0);
            execute_mem_read   = $urandom_range(0, 1) == 1;
            execute_rt         = 5'($urandom_range(0, 3));
            decode_instruction = {ops[$urandom_range(0, 5)], 5'($urandom_range(0, 3)),
                                  5'($urandom_range(0, 3)), 16'($urandom)};
            next_cycle();
        end

        @(negedge clock);
        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipeline_hazard_controller.md
# pipeline_hazard_controller

Sequencing controller for the fetch/decode front end of the five-stage MIPS pipeline. Each cycle it decides whether the PC register and the IF/ID pipeline register advance, hold, or load a bubble. It also decides whether the ID/EX register receives a bubble. Its inputs are load-use hazards, taken branches resolved in EX, and data-memory wait states. It also keeps saturating performance counters for stall cycles and flush events.

## Interface
- FLUSH_CYCLES, 1: cycles that IF/ID is forced to bubble after a redirect; legal range 1..15.
- COUNT_WIDTH, 16: width of each performance counter.

- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- decode_instruction  in  32  current IF/ID instruction word.
- execute_mem_read  in  1  instruction in EX is a load.
- execute_rt  in  5  destination register of the load in EX.
- branch_taken  in  1  EX resolved a taken branch or jump this cycle.
- mem_busy  in  1  data memory is not ready; the whole pipeline must freeze.
- pc_enable  out  1  PC register loads its next value.
- fetch_decode_enable  out  1  IF/ID register captures.
- fetch_decode_flush  out  1  IF/ID captures a NOP (0x00000000) instead of fetched data.
- decode_execute_flush  out  1  ID/EX captures a bubble.
- stall_cycles  out  COUNT_WIDTH  saturating count of cycles with pc_enable=0 while out of reset.
- flush_events  out  COUNT_WIDTH  saturating count of accepted branch_taken events.

## Operation
- **Decode fields:**
  - rs = decode_instruction[25:21].
  - rt = decode_instruction[20:16].
  - op = decode_instruction[31:26].
  - rt counts as a source only when op is 0x00, 0x04, 0x05 or 0x2B.
- **load_use** = execute_mem_read & (execute_rt != 0) & (execute_rt == rs | (rt is a source & execute_rt == rt)).
- **States:** RUN, FLUSH, MEM_WAIT. The block also holds a 4-bit flush_left counter and a 1-bit ret_state (RUN or FLUSH).
- **Priority in every state:** mem_busy > branch_taken > FLUSH activity > load_use > normal.
- **mem_busy = 1 (any state):**
  - All four control outputs are 0.
  - stall_cycles increments.
  - ret_state ← current state; if already in MEM_WAIT, ret_state is kept.
  - Next state is MEM_WAIT.
  - flush_left holds.
  - branch_taken is ignored; upstream holds it stable across the freeze.
- **MEM_WAIT with mem_busy = 0:** the block behaves exactly as ret_state, for both outputs and next state, in that same cycle.
- **RUN, accepted branch_taken:**
  - pc_enable = 1, fetch_decode_enable = 1, fetch_decode_flush = 1, decode_execute_flush = 1.
  - flush_events increments.
  - If FLUSH_CYCLES > 1: flush_left ← FLUSH_CYCLES−1 and next state is FLUSH. Otherwise stay in RUN.
- **RUN, load_use:**
  - pc_enable = 0, fetch_decode_enable = 0, fetch_decode_flush = 0, decode_execute_flush = 1.
  - stall_cycles increments.
  - No state change. The hazard clears by itself once the load leaves EX.
- **RUN, normal:** pc_enable = 1, fetch_decode_enable = 1, both flushes 0.
- **FLUSH:**
  - pc_enable = 1, fetch_decode_enable = 1, fetch_decode_flush = 1, decode_execute_flush = 1.
  - load_use is ignored in this state.
  - flush_left decrements; when flush_left == 1 this cycle, next state is RUN.
  - A branch_taken in FLUSH is accepted as in RUN: flush_events increments and flush_left reloads.
- **Counters:** both saturate at 2^COUNT_WIDTH−1 and never wrap.

## Timing
- All control outputs are combinational from current state and current inputs (zero latency). They must settle within the same cycle the pipeline registers sample them.
- State, flush_left, ret_state and both counters update on the rising edge of clock.
- **While reset = 0:**
  - State is RUN; flush_left = 0; ret_state = RUN; counters are 0.
  - All control outputs are forced to 0 (pipeline frozen).
  - This holds asynchronously, including mid-FLUSH or mid-MEM_WAIT.
- **First edge after reset deasserts:** normal RUN evaluation.
- **Load-use penalty:** exactly 1 cycle per hazard, plus any overlapping mem_busy cycles.
- **Redirect penalty:** FLUSH_CYCLES bubbles in IF/ID, plus any mem_busy cycles inserted in between.

## Test plan
- **Reset:**
  - Hold reset = 0 with mem_busy = 0 and branch_taken = 1 → all outputs 0 and counters 0.
  - Release reset with idle inputs → pc_enable = fetch_decode_enable = 1 and both flushes 0 on the next cycle.
- **Load-use:**
  - Inputs: execute_mem_read = 1, execute_rt = 8, decode_instruction = 0x01095020 (add $10,$8,$9).
  - Required: one cycle with pc_enable = 0, fetch_decode_enable = 0, decode_execute_flush = 1; stall_cycles = 1.
  - Repeat with execute_rt = 0 → no stall.
- **Branch redirect, FLUSH_CYCLES = 3, one-cycle branch_taken pulse:**
  - Required: 3 consecutive cycles of fetch_decode_flush = 1 with pc_enable = 1, then normal operation; flush_events = 1.
- **Freeze inside FLUSH:**
  - FLUSH_CYCLES = 3; assert mem_busy for 3 cycles, starting one cycle after branch_taken.
  - Required: all outputs 0 for those 3 cycles, then the 2 remaining flush cycles, then RUN; stall_cycles = 3.
- **Simultaneous events:**
  - mem_busy = 1 together with load_use and branch_taken → only the freeze occurs (decode_execute_flush = 0, flush_events unchanged).
  - Drop mem_busy with branch_taken still high → the redirect is taken in that cycle.
- **Saturation, COUNT_WIDTH = 4:**
  - Hold mem_busy = 1 for 20 cycles → stall_cycles = 15.
  - Assert reset mid-freeze → counters return to 0 and state returns to RUN immediately.
